// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset control FSM: sequences fetch/decode/execute/writeback and drives datapath selects.
// Latency: data-proc 4, LDR 5, STR 4, B 3, undefined op 2 cycles; outputs are Moore outputs of the state.
// Optional condition/flags logic is enabled by defining MULTICYCLE_CTRL_COND_EN (otherwise cond_ok = 1).
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_control,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  // Plain vectors so unused codes 10-15 are representable.
  logic [3:0] state_q, state_d;
  logic [3:0] cur_state;
  logic       cond_ok;

  logic [3:0] cmd;
  logic       is_cmp;
  logic [1:0] alu_dec;
  logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c;

  assign cmd    = funct[4:1];
  assign is_cmp = (cmd == 4'b1010);

  // While reset is high the block presents FETCH regardless of the register contents.
  assign cur_state = reset ? FETCH : state_q;
  assign state_o   = cur_state;

`ifdef MULTICYCLE_CTRL_COND_EN
  logic [3:0] flags_q;
  logic       n_f, z_f, c_f, v_f;
  logic       flag_we;

  assign {n_f, z_f, c_f, v_f} = flags_q;
  assign flag_we = ((state_q == EXECR) || (state_q == EXECI)) &&
                   (funct[0] || is_cmp) && cond_ok;

  // Flags register: captures ALU flags for flag-setting or compare instructions that pass their condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (flag_we) begin
      flags_q <= alu_flags;
    end
  end

  // Condition evaluation against the registered flags (ARM encoding; 1111 never executes).
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = ~z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = ~c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = ~n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = ~v_f;
      4'b1000: cond_ok = c_f & ~z_f;
      4'b1001: cond_ok = ~c_f | z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = ~z_f & (n_f == v_f);
      4'b1101: cond_ok = z_f | (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
`else
  // Without condition support every instruction executes; cond and ALU flags are ignored.
  logic unused_cond;
  assign unused_cond = ^{cond, alu_flags};
  assign cond_ok     = 1'b1;
`endif

  // State register; reset returns to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // ALU operation decode from the data-processing cmd field.
  always_comb begin
    alu_dec = 2'b00;
    case (cmd)
      4'b0100: alu_dec = 2'b00;
      4'b0010: alu_dec = 2'b01;
      4'b1010: alu_dec = 2'b01;
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      default: alu_dec = 2'b00;
    endcase
  end

  // Instruction-class selects for the immediate extender and register-file read ports.
  always_comb begin
    imm_src = 2'b00;
    case (op)
      2'b01:   imm_src = 2'b01;
      2'b10:   imm_src = 2'b10;
      default: imm_src = 2'b00;
    endcase
    reg_src = {(op == 2'b01), (op == 2'b10)};
  end

  // Next-state and Moore datapath controls; every enable defaults to 0.
  always_comb begin
    state_d     = FETCH;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = 2'b00;
    case (cur_state)
      FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_d    = DECODE;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b00:   state_d = funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        // A load into r15 redirects the PC instead of writing the register file.
        if (rd == 4'd15) begin
          pc_write_c = cond_ok;
        end else begin
          reg_write_c = cond_ok;
        end
        state_d = FETCH;
      end
      MEMWR: begin
        adr_src     = 1'b1;
        mem_write_c = cond_ok;
        state_d     = FETCH;
      end
      EXECR: begin
        alu_src_b   = 2'b00;
        alu_control = alu_dec;
        state_d     = ALUWB;
      end
      EXECI: begin
        alu_src_b   = 2'b01;
        alu_control = alu_dec;
        state_d     = ALUWB;
      end
      ALUWB: begin
        // CMP only updates flags, so it writes neither the register file nor the PC.
        if (rd == 4'd15) begin
          pc_write_c = cond_ok & ~is_cmp;
        end else begin
          reg_write_c = cond_ok & ~is_cmp;
        end
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write_c = cond_ok;
        state_d    = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Reset suppresses every architectural write in the cycle it is asserted.
  assign pc_write  = pc_write_c  & ~reset;
  assign ir_write  = ir_write_c  & ~reset;
  assign mem_write = mem_write_c & ~reset;
  assign reg_write = reg_write_c & ~reset;

endmodule
